// File: rtl/dmem_responder.sv
// Word-addressed data memory responder: valid/ready request, fixed wait states, valid/ready response.
// Optional macro DMEM_RESP_RANGE_CHECK_EN flags word indices >= DEPTH_WORDS instead of wrapping them.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_w_en,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [14:0] DEPTH_L   = 15'(DEPTH_WORDS);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [13:0] cap_widx;
    logic [3:0]  cap_wen;
    logic [31:0] cap_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic        enter_resp;
    logic [13:0] acc_widx;
    logic [3:0]  acc_wen;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic        acc_oor;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // With zero wait states the access happens on the accepting edge, so use the live request.
    assign enter_resp = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd0));

    always_comb begin
        acc_widx  = cap_widx;
        acc_wen   = cap_wen;
        acc_wdata = cap_wdata;
        if (state == S_IDLE) begin
            acc_widx  = req_addr[15:2];
            acc_wen   = req_w_en;
            acc_wdata = req_wdata;
        end
    end

`ifdef DMEM_RESP_RANGE_CHECK_EN
    assign acc_oor = ({1'b0, acc_widx} >= DEPTH_L);
`else
    assign acc_oor = 1'b0;
`endif

    assign acc_idx     = acc_widx[AW-1:0];
    assign rd_word     = mem[acc_idx];
    assign unused_bits = ^{req_addr[1:0], acc_widx, DEPTH_L};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            cap_widx   <= 14'd0;
            cap_wen    <= 4'd0;
            cap_wdata  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_widx  <= req_addr[15:2];
                        cap_wen   <= req_w_en;
                        cap_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (enter_resp) begin
                resp_err   <= acc_oor;
                resp_rdata <= (acc_wen == 4'd0 && !acc_oor) ? rd_word : 32'd0;
            end
        end
    end

    // Storage is never reset; a write commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end
endmodule
